regfile_mp: RTL

- Parametrised multi-port register file; successor to the fixed 16:1 32-bit read mux.
- Holds NREGS registers of WIDTH bits, with NRD independent combinational read ports and one synchronous write port.
- Dedicated program-counter register at index PC_IDX with its own load path.
- Sits between decode (register indices) and the execute datapath (operands).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_rdmux.sv | 46 ++++
 rtl/regfile_mp.sv | 69 ++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, index-width helper and word type for the multi-port register file.
package regfile_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_NREGS     = 16;
  localparam int DEF_NRD       = 3;
  localparam int DEF_PC_IDX    = 15;
  localparam int DEF_PC_RD_OFS = 8;

  // Index width for a file of n registers; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/regfile_rdmux.sv
// One read port: NREGS:1 mux, zero for out-of-range indices, PC offset add.
// REGFILE_BYPASS_EN adds same-cycle write-through forwarding for non-PC indices.
module regfile_rdmux
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NREGS     = DEF_NREGS,
  parameter int AW        = idx_width(DEF_NREGS),
  parameter int PC_IDX    = DEF_PC_IDX,
  parameter int PC_RD_OFS = DEF_PC_RD_OFS
) (
  input  logic [AW-1:0]          ra,
  input  logic [NREGS*WIDTH-1:0] regs,
`ifdef REGFILE_BYPASS_EN
  input  logic                   byp_we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
`endif
  output logic [WIDTH-1:0]       rd
);

  localparam logic [AW-1:0]    PC_A  = AW'(PC_IDX);
  localparam logic [WIDTH-1:0] OFS_W = WIDTH'(PC_RD_OFS);

  logic [WIDTH-1:0] pc_val;
  assign pc_val = regs[PC_IDX*WIDTH +: WIDTH];

`ifdef REGFILE_BYPASS_EN
  localparam logic [AW:0] LIM = (AW+1)'(NREGS);
  logic byp_hit;
  assign byp_hit = byp_we && (ra == wa) && (wa != PC_A) && ({1'b0, wa} < LIM);
`endif

  // Indices with no matching register fall through to zero.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (ra == AW'(i)) rd = regs[i*WIDTH +: WIDTH];
    end
    if (ra == PC_A) rd = pc_val + OFS_W;
`ifdef REGFILE_BYPASS_EN
    if (byp_hit) rd = wd;
`endif
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NRD combinational read ports, one write port, and a
// PC register at PC_IDX with its own load path. Optional macro: REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NREGS     = DEF_NREGS,
  parameter int NRD       = DEF_NRD,
  parameter int PC_IDX    = DEF_PC_IDX,
  parameter int PC_RD_OFS = DEF_PC_RD_OFS,
  localparam int AW       = idx_width(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic                 pc_we,
  input  logic [WIDTH-1:0]     pc_d,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [WIDTH-1:0]     pc_q
);

  logic [NREGS*WIDTH-1:0] regs_q;

  // The general write is checked first so a register write to PC_IDX beats pc_we.
  // Out-of-range wa matches no register and leaves the file untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we && (wa == AW'(i))) begin
          regs_q[i*WIDTH +: WIDTH] <= wd;
        end else if ((i == PC_IDX) && pc_we) begin
          regs_q[i*WIDTH +: WIDTH] <= pc_d;
        end
      end
    end
  end

  assign pc_q = regs_q[PC_IDX*WIDTH +: WIDTH];

`ifdef REGFILE_BYPASS_EN
  logic byp_we;
  assign byp_we = we && !reset;
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rdmux #(
      .WIDTH     (WIDTH),
      .NREGS     (NREGS),
      .AW        (AW),
      .PC_IDX    (PC_IDX),
      .PC_RD_OFS (PC_RD_OFS)
    ) u_rdmux (
      .ra     (ra[k*AW +: AW]),
      .regs   (regs_q),
`ifdef REGFILE_BYPASS_EN
      .byp_we (byp_we),
      .wa     (wa),
      .wd     (wd),
`endif
      .rd     (rd[k*WIDTH +: WIDTH])
    );
  end

endmodule
